// File: rtl/mem_responder.sv
// mem_responder: arbitrates IFU and LSU valid-based requests onto a private
// word-addressed SRAM, serving one request at a time after LATENCY wait cycles
// and answering each with a single-cycle response pulse to its owner.
module mem_responder #(
  parameter logic [31:0] BASE        = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          LATENCY     = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_reqValid,
  input  logic [31:0] ifu_raddr,
  output logic        ifu_respValid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_reqValid,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_respValid,
  output logic [31:0] lsu_rdata,
  output logic        access_fault
);

  localparam int         IDXW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] LAT  = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_addr;
  logic        r_wen;
  logic [31:0] r_wdata;
  logic [3:0]  r_wmask;
  logic        r_ownerLsu;
  logic        r_ifuRespValid;
  logic        r_lsuRespValid;
  logic [31:0] r_ifuRdata;
  logic [31:0] r_lsuRdata;
  logic        r_fault;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic            w_anyReq;
  logic            w_ownerLsu;
  logic [31:0]     w_addr;
  logic            w_wen;
  logic [31:0]     w_wdata;
  logic [3:0]      w_wmask;
  logic            w_commit;
  logic [31:0]     w_wordOff;
  logic            w_inRange;
  logic [IDXW-1:0] w_index;
  logic [31:0]     w_readWord;

  assign w_anyReq = ifu_reqValid | lsu_reqValid;

  // Pick the live request in IDLE (LSU wins ties) so a zero-latency access can
  // commit on the accept edge; otherwise use the request captured at acceptance.
  always_comb begin
    w_ownerLsu = r_ownerLsu;
    w_addr     = r_addr;
    w_wen      = r_wen;
    w_wdata    = r_wdata;
    w_wmask    = r_wmask;
    if (r_state == IDLE) begin
      if (lsu_reqValid) begin
        w_ownerLsu = 1'b1;
        w_addr     = lsu_addr;
        w_wen      = lsu_wen;
        w_wdata    = lsu_wdata;
        w_wmask    = lsu_wmask;
      end else begin
        w_ownerLsu = 1'b0;
        w_addr     = ifu_raddr;
        w_wen      = 1'b0;
        w_wdata    = '0;
        w_wmask    = '0;
      end
    end
  end

  assign w_commit   = (LATENCY == 0) ? ((r_state == IDLE) && w_anyReq)
                                     : ((r_state == WAIT) && (r_cnt == 4'd1));
  assign w_wordOff  = (w_addr - BASE) >> 2;
  assign w_inRange  = (w_addr >= BASE) && (w_wordOff < 32'(DEPTH_WORDS));
  assign w_index    = w_wordOff[IDXW-1:0];
  assign w_readWord = r_mem[w_index];

  // Request FSM: accept, count down the latency, commit, then pulse the owner's response.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= IDLE;
      r_cnt          <= '0;
      r_addr         <= '0;
      r_wen          <= 1'b0;
      r_wdata        <= '0;
      r_wmask        <= '0;
      r_ownerLsu     <= 1'b0;
      r_ifuRespValid <= 1'b0;
      r_lsuRespValid <= 1'b0;
      r_ifuRdata     <= '0;
      r_lsuRdata     <= '0;
      r_fault        <= 1'b0;
    end else begin
      r_ifuRespValid <= 1'b0;
      r_lsuRespValid <= 1'b0;
      r_fault        <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_ownerLsu <= w_ownerLsu;
            r_addr     <= w_addr;
            r_wen      <= w_wen;
            r_wdata    <= w_wdata;
            r_wmask    <= w_wmask;
            if (LATENCY == 0) begin
              r_state <= RESP;
            end else begin
              r_cnt   <= LAT;
              r_state <= WAIT;
            end
          end
        end
        WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= RESP;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
      if (w_commit) begin
        r_fault <= ~w_inRange;
        if (w_ownerLsu) begin
          r_lsuRespValid <= 1'b1;
          r_lsuRdata     <= (w_inRange && !w_wen) ? w_readWord : 32'd0;
        end else begin
          r_ifuRespValid <= 1'b1;
          r_ifuRdata     <= w_inRange ? w_readWord : 32'd0;
        end
      end
    end
  end

  // Byte-masked SRAM write at commit; contents survive reset.
  always_ff @(posedge clk) begin
    if (w_commit && w_wen && w_inRange) begin
      for (int b = 0; b < 4; b++) begin
        if (w_wmask[b]) begin
          r_mem[w_index][8*b +: 8] <= w_wdata[8*b +: 8];
        end
      end
    end
  end

  assign ifu_respValid = r_ifuRespValid;
  assign lsu_respValid = r_lsuRespValid;
  assign ifu_rdata     = r_ifuRdata;
  assign lsu_rdata     = r_lsuRdata;
  assign access_fault  = r_fault;

endmodule
